// File: rtl/csa_resolver.sv
// Resolves a carry-save pair (S, C) to binary R = S + 2*C, CHUNK bits per cycle.
// Optional macro CSA_RESOLVER_OVF_EN adds the out_ovf port (bits above WIDTH).
module csa_resolver #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CSA_RESOLVER_OVF_EN
  ,
  output logic [1:0]       out_ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(WIDTH) + 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("csa_resolver: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] data_q, data_d;
`ifdef CSA_RESOLVER_OVF_EN
  logic             c_msb_q, c_msb_d;
  logic [1:0]       ovf_q, ovf_d;
`endif

  logic [KW-1:0]    k;
  logic [CHUNK-1:0] s_chunk, c_chunk;
  logic [CHUNK:0]   part;
  logic [WIDTH-1:0] chunk_mask;
  logic             last;

  // Chunk arithmetic: select the current slice by shifting, write it back in place.
  always_comb begin
    k          = KW'(cnt_q) * KW'(CHUNK);
    s_chunk    = CHUNK'(s_q >> k);
    c_chunk    = CHUNK'(c_q >> k);
    part       = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK + 1)'(cy_q);
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << k;
    last       = (cnt_q == CW'(N - 1));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cy_d      = cy_q;
    s_d       = s_q;
    c_d       = c_q;
    data_d    = data_q;
`ifdef CSA_RESOLVER_OVF_EN
    c_msb_d   = c_msb_q;
    ovf_d     = ovf_q;
`endif
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = in_sum;
          c_d     = in_carry << 1;
`ifdef CSA_RESOLVER_OVF_EN
          c_msb_d = in_carry[WIDTH-1];
`endif
          cnt_d   = '0;
          cy_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        data_d = (data_q & ~chunk_mask) | ((WIDTH'(part[CHUNK-1:0])) << k);
        cy_d   = part[CHUNK];
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
`ifdef CSA_RESOLVER_OVF_EN
          ovf_d   = {1'b0, part[CHUNK]} + {1'b0, c_msb_q};
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      c_q     <= '0;
      data_q  <= '0;
`ifdef CSA_RESOLVER_OVF_EN
      c_msb_q <= 1'b0;
      ovf_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      c_q     <= c_d;
      data_q  <= data_d;
`ifdef CSA_RESOLVER_OVF_EN
      c_msb_q <= c_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_data = data_q;
`ifdef CSA_RESOLVER_OVF_EN
  assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// Bench for csa_resolver: directed cases on a CHUNK=8 instance, then randomized
// handshakes on CHUNK=8/32/4 instances checked against an arithmetic reference.
module tb_csa_resolver;
  localparam int W        = 32;
  localparam int RAND_CYC = 8000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic rand_go = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full-precision sum; low W bits are the result, bits above are the overflow.
  function automatic logic [63:0] ref_total(input logic [W-1:0] s, input logic [W-1:0] c);
    return 64'(s) + 64'(2) * 64'(c);
  endfunction

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_sum, in_carry, out_data;
`ifdef CSA_RESOLVER_OVF_EN
  logic [1:0]   out_ovf;
`endif

  csa_resolver #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
`ifdef CSA_RESOLVER_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  task automatic accept(input logic [W-1:0] s, input logic [W-1:0] c);
    @(negedge clk);
    in_sum = s; in_carry = c; in_valid = 1'b1; out_ready = 1'b0;
    check("accept_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [W-1:0] exp_d, input logic [1:0] exp_o);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_data"}, out_data, exp_d);
    check({name, "_in_ready_busy"}, in_ready, 0);
`ifdef CSA_RESOLVER_OVF_EN
    check({name, "_ovf"}, out_ovf, exp_o);
`else
    if (exp_o > 2'd2) check({name, "_ovf_range"}, exp_o, 0);
`endif
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_out_valid_after"}, out_valid, 0);
    check({name, "_in_ready_after"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] s, input logic [W-1:0] c,
                        input logic [W-1:0] exp_d, input logic [1:0] exp_o);
    accept(s, c);
    wait_result(name, exp_d, exp_o);
    $display("op %s S=%08h C=%08h R=%08h", name, s, c, out_data);
    release_result(name);
  endtask

  // Randomized instances at three chunk sizes, each with its own driver/monitor.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rand
      localparam int C = (gi == 0) ? 8 : ((gi == 1) ? 32 : 4);
      logic         iv, ir, ov, orr;
      logic [W-1:0] is, ic, od;
`ifdef CSA_RESOLVER_OVF_EN
      logic [1:0]   oo;
`endif
      csa_resolver #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir),
        .in_sum(is), .in_carry(ic),
        .out_valid(ov), .out_ready(orr),
        .out_data(od)
`ifdef CSA_RESOLVER_OVF_EN
        , .out_ovf(oo)
`endif
      );

      initial begin : p_rand
        logic [63:0]  q[$];
        logic [63:0]  e;
        logic         hold;
        logic [W-1:0] held;
        int           n;
        iv = 1'b0; orr = 1'b0; is = '0; ic = '0;
        hold = 1'b0; held = '0; n = 0;
        wait (rand_go);
        for (int cyc = 0; cyc < RAND_CYC; cyc++) begin
          @(negedge clk);
          if (hold) begin
            check($sformatf("rnd%0d_hold_valid", C), ov, 1);
            check($sformatf("rnd%0d_hold_data", C), od, held);
          end
          if (!(iv && !ir)) begin
            iv = ($urandom_range(0, 3) != 0);
            is = $urandom;
            ic = $urandom;
          end
          orr = ($urandom_range(0, 2) != 0);
          if (iv && ir) q.push_back(ref_total(is, ic));
          if (ov && orr) begin
            if (q.size() == 0) begin
              check($sformatf("rnd%0d_spurious", C), ov, 0);
            end else begin
              e = q.pop_front();
              n++;
              check($sformatf("rnd%0d_data", C), od, e[W-1:0]);
`ifdef CSA_RESOLVER_OVF_EN
              check($sformatf("rnd%0d_ovf", C), oo, e[33:32]);
`endif
              $display("rnd chunk=%0d #%0d R=%08h", C, n, od);
            end
          end
          hold = ov && !orr;
          held = od;
        end
        iv = 1'b0; orr = 1'b0;
        check($sformatf("rnd%0d_pending", C), (q.size() <= 1), 1);
        check($sformatf("rnd%0d_some_results", C), (n > 50), 1);
      end
    end
  endgenerate

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_carry = '0;
    repeat (3) @(negedge clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef CSA_RESOLVER_OVF_EN
    check("rst_out_ovf", out_ovf, 0);
`endif
    rst_n = 1'b1;

    run_op("small",   32'h0000_0001, 32'h0000_0001, 32'h0000_0003, 2'd0);
    run_op("ripple",  32'h0000_FFFF, 32'h0000_0001, 32'h0001_0001, 2'd0);
    run_op("wrap1",   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 2'd1);
    run_op("wrap2",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2'd2);
    begin
      logic [63:0] e;
      logic [W-1:0] s, c;
      for (int i = 0; i < 4; i++) begin
        s = $urandom; c = $urandom;
        e = ref_total(s, c);
        run_op($sformatf("dir_rand%0d", i), s, c, e[W-1:0], e[33:32]);
      end
    end

    // Backpressure in DONE while a competing input is offered
    accept(32'h1234_5678, 32'h1111_1111);
    wait_result("stall", 32'h3456_789A, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sum = $urandom; in_carry = $urandom; out_ready = 1'b0;
      @(posedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 32'h3456_789A);
      check("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_release_valid", out_valid, 0);
    check("stall_release_in_ready", in_ready, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 check("stall_not_accepted", in_ready, 1);
    $display("op stall R=%08h released", out_data);

    // Reset during the second RUN cycle
    accept(32'hA5A5_A5A5, 32'h0F0F_0F0F);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_data", out_data, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
`ifdef CSA_RESOLVER_OVF_EN
    check("abort_out_ovf", out_ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    $display("op abort reset applied mid-run");
    run_op("after_abort", 32'h7FFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 2'd0);

    rand_go = 1'b1;
    repeat (RAND_CYC + 10) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
